// File: rtl/priority_codec_pkg.sv
// Shared constants, FSM state type and code-classification helper for the
// priority-code receive path.
package priority_codec_pkg;

    localparam logic [7:0] NONE_CODE = 8'hF0;
    localparam int         IDX_W     = 4;
    localparam int         VEC_W     = 16;

    typedef enum logic {
        HOLD   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // A valid index has an all-zero upper nibble (8'h00..8'h0F).
    function automatic logic is_valid_idx(input logic [7:0] code);
        return (code[7:IDX_W] == 4'h0);
    endfunction

endpackage

// File: rtl/code_debounce.sv
// Synchronises the incoming priority code and qualifies it: a code must be
// seen STABLE_CYCLES consecutive times before a one-cycle accept strobe.
module code_debounce
    import priority_codec_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    output logic       accept,
    output logic [7:0] code
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [7:0] sync1_r;
    logic [7:0] sync2_r;
    logic [7:0] cand_r;
    logic [7:0] cnt_r;
    state_t     state_r;

    logic [7:0] cand_s;
    logic [7:0] cnt_s;
    state_t     state_s;

    // Two-flop synchroniser for the off-chip code bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= NONE_CODE;
            sync2_r <= NONE_CODE;
        end else begin
            sync1_r <= code_in;
            sync2_r <= sync1_r;
        end
    end

    // State register with candidate and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HOLD;
            cand_r  <= NONE_CODE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: any change restarts qualification, whatever the state.
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        cnt_s   = cnt_r;
        if (sync2_r != cand_r) begin
            cand_s  = sync2_r;
            cnt_s   = 8'd0;
            state_s = SETTLE;
        end else begin
            case (state_r)
                SETTLE: begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = HOLD;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                HOLD:    state_s = HOLD;
                default: state_s = HOLD;
            endcase
        end
    end

    // Output logic: strobe on the edge that completes qualification.
    always_comb begin
        code = cand_r;
        if ((state_r == SETTLE) && (sync2_r == cand_r) && (cnt_r == CNT_LAST)) begin
            accept = 1'b1;
        end else begin
            accept = 1'b0;
        end
    end

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Priority-code receiver: regenerates a registered 16-bit one-hot vector from
// the qualified code. Define PULSE_MODE_EN for fixed-length pulses instead of levels.
module tt_um_priority_decoder
    import priority_codec_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PULSE_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic             accept_s;
    logic [7:0]       code_s;
    logic [VEC_W-1:0] onehot_r;
    logic             unused_s;

    code_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .code_in(ui_in),
        .accept (accept_s),
        .code   (code_s)
    );

`ifdef PULSE_MODE_EN
    logic [7:0] timer_r;

    // One-hot pulse register: each valid accept (re)starts a PULSE_LEN pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_r <= 16'h0000;
            timer_r  <= 8'd0;
        end else if (accept_s && is_valid_idx(code_s)) begin
            onehot_r <= 16'h0001 << code_s[IDX_W-1:0];
            timer_r  <= 8'(PULSE_LEN);
        end else if (accept_s && (code_s == NONE_CODE)) begin
            onehot_r <= 16'h0000;
            timer_r  <= 8'd0;
        end else if (timer_r == 8'd1) begin
            onehot_r <= 16'h0000;
            timer_r  <= 8'd0;
        end else if (timer_r != 8'd0) begin
            timer_r  <= timer_r - 8'd1;
        end else begin
            onehot_r <= onehot_r;
        end
    end
`else
    // One-hot level register: invalid codes leave the last vector in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_r <= 16'h0000;
        end else if (accept_s && is_valid_idx(code_s)) begin
            onehot_r <= 16'h0001 << code_s[IDX_W-1:0];
        end else if (accept_s && (code_s == NONE_CODE)) begin
            onehot_r <= 16'h0000;
        end else begin
            onehot_r <= onehot_r;
        end
    end
`endif

    assign uo_out   = onehot_r[15:8];
    assign uio_out  = onehot_r[7:0];
    assign uio_oe   = 8'hFF;
    assign unused_s = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Directed self-checking bench for tt_um_priority_decoder (level mode by
// default; pulse-mode vectors when PULSE_MODE_EN is defined).
module tb_tt_um_priority_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fail;

    tt_um_priority_decoder #(
        .STABLE_CYCLES(4),
        .PULSE_LEN    (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, checking the 16-bit vector and uio_oe after each.
    task automatic run(input string tag, input int n, input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            check_eq(tag, {uo_out, uio_out}, exp);
            check_eq({tag, "_oe"}, {8'h00, uio_oe}, 16'h00FF);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ena      = 1'b1;
        uio_in   = 8'h00;
        ui_in    = 8'hF0;
        rst_n    = 1'b0;
        #1;
        check_eq("reset_vec", {uo_out, uio_out}, 16'h0000);
        check_eq("reset_oe", {8'h00, uio_oe}, 16'h00FF);
        #22;
        rst_n = 1'b1;
        run("idle", 3, 16'h0000);

`ifdef PULSE_MODE_EN
        ui_in = 8'h00;
        run("p1_wait", 6, 16'h0000);
        run("p1_on", 8, 16'h0001);
        run("p1_off", 6, 16'h0000);

        ui_in = 8'hF0;
        step();
        ui_in = 8'h00;
        run("p2_wait", 6, 16'h0000);
        run("p2_on", 8, 16'h0001);
        run("p2_off", 4, 16'h0000);

        ui_in = 8'hF0;
        run("p3_idle", 10, 16'h0000);
        ui_in = 8'h00;
        run("p3_wait", 5, 16'h0000);
        ui_in = 8'h04;
        run("p3_wait2", 1, 16'h0000);
        run("p3_first", 5, 16'h0001);
        run("p3_restart", 8, 16'h0010);
        run("p3_off", 3, 16'h0000);
`else
        ui_in = 8'h05;
        run("lat_wait", 6, 16'h0000);
        run("lat_accept", 1, 16'h0020);

        ui_in = 8'h0F;
        run("f_wait", 6, 16'h0020);
        run("f_accept", 1, 16'h8000);
        ui_in = 8'hF0;
        run("none_wait", 6, 16'h8000);
        run("none_clear", 1, 16'h0000);

        ui_in = 8'h03;
        run("g_wait", 6, 16'h0000);
        run("g_accept", 1, 16'h0008);
        ui_in = 8'h0A;
        run("glitch", 2, 16'h0008);
        ui_in = 8'h03;
        run("glitch_ret", 15, 16'h0008);

        ui_in = 8'h02;
        run("i_wait", 6, 16'h0008);
        run("i_accept", 1, 16'h0004);
        ui_in = 8'h37;
        run("invalid", 20, 16'h0004);

        ui_in = 8'h08;
        run("r_wait", 6, 16'h0004);
        run("r_accept", 1, 16'h0100);
        ui_in = 8'h01;
        run("r_settle", 4, 16'h0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", {uo_out, uio_out}, 16'h0000);
        @(negedge clk);
        check_eq("reset_held", {uo_out, uio_out}, 16'h0000);
        rst_n = 1'b1;
        run("post_wait", 6, 16'h0000);
        run("post_accept", 1, 16'h0002);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
